dm_sba_master: RTL and testbench

- Bus-master side of System Bus Access in the debug module.
- Consumes the access triggers and SBCS fields from the SBA register block, then runs one 32-bit transaction on the system bus (req/gnt/rvalid protocol).
- Returns read data, error status, busy and the auto-incremented address to the register block.
- One transaction at a time; no outstanding pipelining.

---
 rtl/dm_sba_master.sv | 236 +++++++++++++++++++++++
 tb/tb_dm_sba_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_master.sv
// dm_sba_master: bus-master side of debug-module System Bus Access.
// Takes the SBA access triggers and SBCS fields from the register block.
// Runs one 32-bit req/gnt/rvalid transaction at a time on the system bus.
// Returns read data, error code, busy and the post-access address.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   sb*_i                  SBAddress0/SBData0 values, access strobes, SBCS fields
//   sbaddress_o            address after the access (auto-incremented on success)
//   sbdata_o/_valid_o      right-aligned read data and its one-cycle pulse
//   sbbusy_o               transaction in flight (REQ/WAIT)
//   sberror_o/_valid_o     error code and its one-cycle pulse
//   master_*               system-bus master port
//
// Optional feature: define SBA_TIMEOUT_EN to abort with sberror=1 when gnt or
// rvalid does not arrive within TimeoutCycles cycles.
module dm_sba_master #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [BusWidth-1:0] sbaddress_i,
  input  logic [BusWidth-1:0] sbdata_i,
  input  logic                sbaddress_write_valid_i,
  input  logic                sbdata_read_valid_i,
  input  logic                sbdata_write_valid_i,
  input  logic                sbautoincrement_i,
  input  logic                sbreadonaddr_i,
  input  logic                sbreadondata_i,
  input  logic [2:0]          sbaccess_i,
  output logic [BusWidth-1:0] sbaddress_o,
  output logic [BusWidth-1:0] sbdata_o,
  output logic                sbdata_valid_o,
  output logic                sbbusy_o,
  output logic [2:0]          sberror_o,
  output logic                sberror_valid_o,
  output logic                master_req_o,
  output logic [BusWidth-1:0] master_add_o,
  output logic                master_we_o,
  output logic [BusWidth-1:0] master_wdata_o,
  output logic [3:0]          master_be_o,
  input  logic                master_gnt_i,
  input  logic                master_r_valid_i,
  input  logic                master_r_err_i,
  input  logic [BusWidth-1:0] master_r_rdata_i
);

  // Only a 32-bit bus and a non-trivial timeout are meaningful.
  if (BusWidth != 32 || TimeoutCycles < 2) begin : g_param_check
    $error("dm_sba_master: unsupported BusWidth or TimeoutCycles");
  end

  typedef enum logic [1:0] {Idle, Req, Wait, Done} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    access_q, access_d;
  logic          autoinc_q, autoinc_d;
  logic          req_d, busy_d, we_d;
  logic [31:0]   add_d, wdata_d, sbaddress_d, sbdata_d;
  logic [3:0]    be_d;
  logic          sbdata_valid_d, sberror_valid_d;
  logic [2:0]    sberror_d;

  logic          trig_write, trig_read, misaligned;
  logic [31:0]   rdata_shifted, rdata_mask;
  logic          timeout_hit;

`ifdef SBA_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] cnt_q, cnt_d;
  assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign trig_write = sbdata_write_valid_i;
  assign trig_read  = (sbaddress_write_valid_i & sbreadonaddr_i) |
                      (sbdata_read_valid_i & sbreadondata_i);

  // Alignment to 2^sbaccess bytes; only meaningful for sbaccess <= 2.
  always_comb begin
    misaligned = 1'b0;
    case (sbaccess_i)
      3'd1:    misaligned = sbaddress_i[0];
      3'd2:    misaligned = |sbaddress_i[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Read data right-aligned from the addressed lane, then masked to size.
  assign rdata_shifted = master_r_rdata_i >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (access_q)
      2'd0:    rdata_mask = 32'h0000_00FF;
      2'd1:    rdata_mask = 32'h0000_FFFF;
      default: rdata_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    access_d        = access_q;
    autoinc_d       = autoinc_q;
    we_d            = master_we_o;
    add_d           = master_add_o;
    wdata_d         = master_wdata_o;
    be_d            = master_be_o;
    sbaddress_d     = sbaddress_o;
    sbdata_d        = sbdata_o;
    sberror_d       = sberror_o;
    sbdata_valid_d  = 1'b0;
    sberror_valid_d = 1'b0;
`ifdef SBA_TIMEOUT_EN
    cnt_d           = cnt_q + CntW'(1);
`endif

    case (state_q)
      Idle: begin
        if (trig_write || trig_read) begin
          addr_d    = sbaddress_i;
          access_d  = sbaccess_i[1:0];
          autoinc_d = sbautoincrement_i;
          if (sbaccess_i > 3'd2) begin
            sberror_d       = 3'd4;
            sberror_valid_d = 1'b1;
          end else if (misaligned) begin
            sberror_d       = 3'd3;
            sberror_valid_d = 1'b1;
          end else begin
            state_d = Req;
            we_d    = trig_write;
            add_d   = {sbaddress_i[31:2], 2'b00};
            wdata_d = sbdata_i << {sbaddress_i[1:0], 3'b000};
            case (sbaccess_i[1:0])
              2'd0:    be_d = 4'b0001 << sbaddress_i[1:0];
              2'd1:    be_d = 4'b0011 << sbaddress_i[1:0];
              default: be_d = 4'b1111;
            endcase
          end
        end
`ifdef SBA_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      Req: begin
        if (master_gnt_i) begin
          state_d = Wait;
`ifdef SBA_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (timeout_hit) begin
          state_d         = Done;
          sberror_d       = 3'd1;
          sberror_valid_d = 1'b1;
          sbaddress_d     = addr_q;
        end
      end
      Wait: begin
        if (master_r_valid_i) begin
          state_d = Done;
          if (master_r_err_i) begin
            sberror_d       = 3'd2;
            sberror_valid_d = 1'b1;
            sbaddress_d     = addr_q;
          end else begin
            sberror_d   = 3'd0;
            sbaddress_d = autoinc_q ? addr_q + (32'd1 << access_q) : addr_q;
            if (!master_we_o) begin
              sbdata_d       = rdata_shifted & rdata_mask;
              sbdata_valid_d = 1'b1;
            end
          end
        end else if (timeout_hit) begin
          state_d         = Done;
          sberror_d       = 3'd1;
          sberror_valid_d = 1'b1;
          sbaddress_d     = addr_q;
        end
      end
      default: begin
        state_d = Idle;
      end
    endcase

    req_d  = (state_d == Req);
    busy_d = (state_d == Req) || (state_d == Wait);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= Idle;
      addr_q          <= '0;
      access_q        <= '0;
      autoinc_q       <= 1'b0;
      master_req_o    <= 1'b0;
      master_add_o    <= '0;
      master_we_o     <= 1'b0;
      master_wdata_o  <= '0;
      master_be_o     <= '0;
      sbaddress_o     <= '0;
      sbdata_o        <= '0;
      sbdata_valid_o  <= 1'b0;
      sbbusy_o        <= 1'b0;
      sberror_o       <= '0;
      sberror_valid_o <= 1'b0;
`ifdef SBA_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      access_q        <= access_d;
      autoinc_q       <= autoinc_d;
      master_req_o    <= req_d;
      master_add_o    <= add_d;
      master_we_o     <= we_d;
      master_wdata_o  <= wdata_d;
      master_be_o     <= be_d;
      sbaddress_o     <= sbaddress_d;
      sbdata_o        <= sbdata_d;
      sbdata_valid_o  <= sbdata_valid_d;
      sbbusy_o        <= busy_d;
      sberror_o       <= sberror_d;
      sberror_valid_o <= sberror_valid_d;
`ifdef SBA_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dm_sba_master.sv
// Directed self-checking bench for dm_sba_master (default build).
module tb_dm_sba_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] sbaddress_i, sbdata_i;
  logic        sbaddress_write_valid_i, sbdata_read_valid_i, sbdata_write_valid_i;
  logic        sbautoincrement_i, sbreadonaddr_i, sbreadondata_i;
  logic [2:0]  sbaccess_i;
  logic [31:0] sbaddress_o, sbdata_o;
  logic        sbdata_valid_o, sbbusy_o;
  logic [2:0]  sberror_o;
  logic        sberror_valid_o;
  logic        master_req_o;
  logic [31:0] master_add_o;
  logic        master_we_o;
  logic [31:0] master_wdata_o;
  logic [3:0]  master_be_o;
  logic        master_gnt_i, master_r_valid_i, master_r_err_i;
  logic [31:0] master_r_rdata_i;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_master dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .sbaddress_i             (sbaddress_i),
    .sbdata_i                (sbdata_i),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbreadondata_i          (sbreadondata_i),
    .sbaccess_i              (sbaccess_i),
    .sbaddress_o             (sbaddress_o),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbbusy_o                (sbbusy_o),
    .sberror_o               (sberror_o),
    .sberror_valid_o         (sberror_valid_o),
    .master_req_o            (master_req_o),
    .master_add_o            (master_add_o),
    .master_we_o             (master_we_o),
    .master_wdata_o          (master_wdata_o),
    .master_be_o             (master_be_o),
    .master_gnt_i            (master_gnt_i),
    .master_r_valid_i        (master_r_valid_i),
    .master_r_err_i          (master_r_err_i),
    .master_r_rdata_i        (master_r_rdata_i)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_triggers();
    sbaddress_write_valid_i = 1'b0;
    sbdata_read_valid_i     = 1'b0;
    sbdata_write_valid_i    = 1'b0;
  endtask

  task automatic bus_idle();
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_err_i   = 1'b0;
    master_r_rdata_i = 32'h0;
  endtask

  // Grant in the first REQ cycle, respond in the next cycle.
  task automatic grant_and_respond(input logic [31:0] rdata, input logic err);
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b1;
    master_r_err_i   = err;
    master_r_rdata_i = rdata;
    tick();
    bus_idle();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    check_cnt++;
    if (master_req_o !== 1'b0) $display("FAIL reset_req: got %0b want 0", master_req_o);
    else pass_cnt++;
    check_cnt++;
    if (sbbusy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", sbbusy_o);
    else pass_cnt++;
    check_cnt++;
    if ({sbdata_valid_o, sberror_valid_o, sberror_o} !== 5'b0)
      $display("FAIL reset_pulses: got %05b want 00000", {sbdata_valid_o, sberror_valid_o, sberror_o});
    else pass_cnt++;
    check_cnt++;
    if (sbaddress_o !== 32'h0 || sbdata_o !== 32'h0)
      $display("FAIL reset_data: got addr %08h data %08h want 0 0", sbaddress_o, sbdata_o);
    else pass_cnt++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_word_read();
    sbaddress_i = 32'h0000_1000; sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1;
    sbautoincrement_i = 1'b0; sbaddress_write_valid_i = 1'b1;
    tick();                                  // trigger + 1: REQ
    clear_triggers();
    check_cnt++;
    if (master_req_o !== 1'b1 || master_we_o !== 1'b0 || sbbusy_o !== 1'b1)
      $display("FAIL word_read_req: got req %0b we %0b busy %0b want 1 0 1", master_req_o, master_we_o, sbbusy_o);
    else pass_cnt++;
    check_cnt++;
    if (master_add_o !== 32'h0000_1000 || master_be_o !== 4'hF)
      $display("FAIL word_read_addr_be: got %08h %h want 00001000 f", master_add_o, master_be_o);
    else pass_cnt++;
    master_gnt_i = 1'b1;
    tick();                                  // trigger + 2: WAIT
    master_gnt_i = 1'b0;
    check_cnt++;
    if (master_req_o !== 1'b0 || sbbusy_o !== 1'b1 || sbdata_valid_o !== 1'b0)
      $display("FAIL word_read_wait: got req %0b busy %0b dv %0b want 0 1 0", master_req_o, sbbusy_o, sbdata_valid_o);
    else pass_cnt++;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEAD_BEEF;
    tick();                                  // trigger + 3: DONE
    bus_idle();
    check_cnt++;
    if (sbdata_valid_o !== 1'b1 || sbdata_o !== 32'hDEAD_BEEF)
      $display("FAIL word_read_data: got dv %0b data %08h want 1 deadbeef", sbdata_valid_o, sbdata_o);
    else pass_cnt++;
    check_cnt++;
    if (sbaddress_o !== 32'h0000_1000 || sbbusy_o !== 1'b0 || sberror_valid_o !== 1'b0)
      $display("FAIL word_read_done: got addr %08h busy %0b ev %0b want 00001000 0 0", sbaddress_o, sbbusy_o, sberror_valid_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (sbdata_valid_o !== 1'b0) $display("FAIL word_read_pulse_width: got %0b want 0", sbdata_valid_o);
    else pass_cnt++;
    sbreadonaddr_i = 1'b0;
  endtask

  task automatic test_byte_write();
    sbaddress_i = 32'h0000_2003; sbdata_i = 32'h0000_00A5; sbaccess_i = 3'd0;
    sbautoincrement_i = 1'b1; sbdata_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (master_req_o !== 1'b1 || master_we_o !== 1'b1 || master_add_o !== 32'h0000_2000)
      $display("FAIL byte_write_req: got req %0b we %0b add %08h want 1 1 00002000", master_req_o, master_we_o, master_add_o);
    else pass_cnt++;
    check_cnt++;
    if (master_be_o !== 4'b1000 || master_wdata_o !== 32'hA500_0000)
      $display("FAIL byte_write_lane: got be %04b wdata %08h want 1000 a5000000", master_be_o, master_wdata_o);
    else pass_cnt++;
    grant_and_respond(32'h0, 1'b0);
    check_cnt++;
    if (sbaddress_o !== 32'h0000_2004 || sbdata_valid_o !== 1'b0 || sberror_valid_o !== 1'b0)
      $display("FAIL byte_write_done: got addr %08h dv %0b ev %0b want 00002004 0 0", sbaddress_o, sbdata_valid_o, sberror_valid_o);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_halfword_readondata();
    sbaddress_i = 32'h0000_3002; sbaccess_i = 3'd1; sbreadondata_i = 1'b1;
    sbautoincrement_i = 1'b1; sbdata_read_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (master_add_o !== 32'h0000_3000 || master_be_o !== 4'b1100 || master_we_o !== 1'b0)
      $display("FAIL half_read_req: got add %08h be %04b we %0b want 00003000 1100 0", master_add_o, master_be_o, master_we_o);
    else pass_cnt++;
    grant_and_respond(32'h1234_5678, 1'b0);
    check_cnt++;
    if (sbdata_valid_o !== 1'b1 || sbdata_o !== 32'h0000_1234 || sbaddress_o !== 32'h0000_3004)
      $display("FAIL half_read_done: got dv %0b data %08h addr %08h want 1 00001234 00003004", sbdata_valid_o, sbdata_o, sbaddress_o);
    else pass_cnt++;
    tick();
    // Register block now holds the incremented address; next SBData0 read triggers again.
    sbaddress_i = 32'h0000_3004; sbdata_read_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (master_req_o !== 1'b1 || master_add_o !== 32'h0000_3004 || master_be_o !== 4'b0011)
      $display("FAIL half_read_next: got req %0b add %08h be %04b want 1 00003004 0011", master_req_o, master_add_o, master_be_o);
    else pass_cnt++;
    grant_and_respond(32'hAAAA_5555, 1'b0);
    check_cnt++;
    if (sbdata_o !== 32'h0000_5555 || sbaddress_o !== 32'h0000_3006)
      $display("FAIL half_read_next_done: got data %08h addr %08h want 00005555 00003006", sbdata_o, sbaddress_o);
    else pass_cnt++;
    tick();
    sbreadondata_i = 1'b0;
  endtask

  task automatic test_wrap();
    sbaddress_i = 32'hFFFF_FFFC; sbdata_i = 32'h1111_2222; sbaccess_i = 3'd2;
    sbautoincrement_i = 1'b1; sbdata_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (master_wdata_o !== 32'h1111_2222 || master_add_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req: got wdata %08h add %08h want 11112222 fffffffc", master_wdata_o, master_add_o);
    else pass_cnt++;
    grant_and_respond(32'h0, 1'b0);
    check_cnt++;
    if (sbaddress_o !== 32'h0) $display("FAIL wrap_addr: got %08h want 00000000", sbaddress_o);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_errors();
    // Unsupported size.
    sbaddress_i = 32'h0000_0100; sbaccess_i = 3'd3; sbdata_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd4 || master_req_o !== 1'b0 || sbbusy_o !== 1'b0)
      $display("FAIL err_size: got ev %0b err %0d req %0b busy %0b want 1 4 0 0", sberror_valid_o, sberror_o, master_req_o, sbbusy_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (sberror_valid_o !== 1'b0 || master_req_o !== 1'b0)
      $display("FAIL err_size_after: got ev %0b req %0b want 0 0", sberror_valid_o, master_req_o);
    else pass_cnt++;
    // Misaligned word.
    sbaddress_i = 32'h0000_4001; sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd3 || master_req_o !== 1'b0 || sbbusy_o !== 1'b0)
      $display("FAIL err_align_word: got ev %0b err %0d req %0b busy %0b want 1 3 0 0", sberror_valid_o, sberror_o, master_req_o, sbbusy_o);
    else pass_cnt++;
    tick();
    // Misaligned halfword.
    sbaccess_i = 3'd1; sbaddress_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd3 || master_req_o !== 1'b0)
      $display("FAIL err_align_half: got ev %0b err %0d req %0b want 1 3 0", sberror_valid_o, sberror_o, master_req_o);
    else pass_cnt++;
    tick();
    // Bus error response: no data pulse, no increment.
    sbaddress_i = 32'h0000_4000; sbaccess_i = 3'd2; sbautoincrement_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    grant_and_respond(32'hCAFE_F00D, 1'b1);
    check_cnt++;
    if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd2 || sbdata_valid_o !== 1'b0)
      $display("FAIL err_bus: got ev %0b err %0d dv %0b want 1 2 0", sberror_valid_o, sberror_o, sbdata_valid_o);
    else pass_cnt++;
    check_cnt++;
    if (sbaddress_o !== 32'h0000_4000) $display("FAIL err_bus_addr: got %08h want 00004000", sbaddress_o);
    else pass_cnt++;
    tick();
    sbreadonaddr_i = 1'b0;
  endtask

  task automatic test_write_wins();
    sbaddress_i = 32'h0000_7000; sbdata_i = 32'h0BAD_F00D; sbaccess_i = 3'd2; sbautoincrement_i = 1'b0;
    sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1; sbdata_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    check_cnt++;
    if (master_we_o !== 1'b1 || master_wdata_o !== 32'h0BAD_F00D)
      $display("FAIL write_wins: got we %0b wdata %08h want 1 0badf00d", master_we_o, master_wdata_o);
    else pass_cnt++;
    grant_and_respond(32'h0, 1'b0);
    tick();
    sbreadonaddr_i = 1'b0;
  endtask

  task automatic test_stall_and_ignore();
    int bad;
    sbaddress_i = 32'h0000_5000; sbaccess_i = 3'd2; sbautoincrement_i = 1'b0;
    sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        // Foreign trigger while busy must be ignored.
        sbaddress_i = 32'h0000_9004; sbdata_write_valid_i = 1'b1;
      end
      if (master_req_o !== 1'b1 || master_add_o !== 32'h0000_5000 || master_we_o !== 1'b0 || sbbusy_o !== 1'b1)
        bad++;
      tick();
      clear_triggers();
    end
    check_cnt++;
    if (bad !== 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", bad);
    else pass_cnt++;
    grant_and_respond(32'h5A5A_0001, 1'b0);
    check_cnt++;
    if (sbdata_o !== 32'h5A5A_0001 || sbaddress_o !== 32'h0000_5000 || sbdata_valid_o !== 1'b1)
      $display("FAIL stall_done: got data %08h addr %08h dv %0b want 5a5a0001 00005000 1", sbdata_o, sbaddress_o, sbdata_valid_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (master_req_o !== 1'b0 || sbbusy_o !== 1'b0)
      $display("FAIL stall_idle: got req %0b busy %0b want 0 0", master_req_o, sbbusy_o);
    else pass_cnt++;
    sbreadonaddr_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    sbaddress_i = 32'h0000_6000; sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    tick();
    clear_triggers();
    master_gnt_i = 1'b1;
    tick();                                  // now in WAIT
    master_gnt_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_cnt++;
    if (sbbusy_o !== 1'b0 || master_req_o !== 1'b0)
      $display("FAIL rst_wait: got busy %0b req %0b want 0 0", sbbusy_o, master_req_o);
    else pass_cnt++;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h7777_7777;
    tick();
    bus_idle();
    check_cnt++;
    if (sbdata_valid_o !== 1'b0 || sberror_valid_o !== 1'b0 || sbbusy_o !== 1'b0)
      $display("FAIL rst_late_rvalid: got dv %0b ev %0b busy %0b want 0 0 0", sbdata_valid_o, sberror_valid_o, sbbusy_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (sbdata_valid_o !== 1'b0 || sbdata_o !== 32'h0)
      $display("FAIL rst_late_data: got dv %0b data %08h want 0 00000000", sbdata_valid_o, sbdata_o);
    else pass_cnt++;
    sbreadonaddr_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    sbaddress_i = '0; sbdata_i = '0; sbaccess_i = '0;
    sbautoincrement_i = 1'b0; sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0;
    clear_triggers();
    bus_idle();
    test_reset();
    test_word_read();
    test_byte_write();
    test_halfword_readondata();
    test_wrap();
    test_errors();
    test_write_wins();
    test_stall_and_ignore();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, check_cnt);
    $fatal(1);
  end

endmodule
